// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for ALU/LSU results into the register file, with a busy
// scoreboard that stalls issue on RAW/WAW hazards against in-flight destinations.
module regfile_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rs1,
  input  logic [AW-1:0]        issue_rs2,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_ready,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [AW-1:0]        lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 lsu_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [(2**AW)-1:0]   busy
);

  localparam int unsigned NREG = 2**AW;

  logic            last_lsu_q, last_lsu_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            alu_gnt, lsu_gnt, xfer, hazard, issue_acc;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        alu_gnt = last_lsu_q;
        lsu_gnt = !last_lsu_q;
      end else begin
        alu_gnt = alu_valid;
        lsu_gnt = lsu_valid;
      end
    end
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign xfer      = alu_gnt | lsu_gnt;
  assign wb_rd     = lsu_gnt ? lsu_rd : alu_rd;
  assign wb_data   = lsu_gnt ? lsu_data : alu_data;

  // No bypass: a register retiring this cycle still blocks issue.
  assign hazard      = busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd];
  assign issue_ready = !hazard && !rst;
  assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    last_lsu_d = last_lsu_q;
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      last_lsu_d     = lsu_gnt;
      rf_we_d        = (wb_rd != '0);
      rf_rd_d        = wb_rd;
      rf_wdata_d     = wb_data;
      busy_d[wb_rd]  = 1'b0;
    end
    // Set after clear so a same-index issue wins.
    if (issue_acc) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_q <= 1'b1;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_lsu_q <= last_lsu_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios followed by
// randomized traffic, all checked against a scoreboard-level reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Reference state: which registers have an outstanding writer, who was served last.
  bit          busy_m [32];
  bit          lsu_was_last_m;
  bit          we_m;
  logic [4:0]  rd_m;
  logic [31:0] wdata_m;

  regfile_wb_scheduler #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    lsu_was_last_m = 1'b1;
    we_m    = 1'b0;
    rd_m    = '0;
    wdata_m = '0;
  endtask

  // One clock cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic r, input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic av, input logic [4:0] ard,
                      input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ldat, output logic ga, output logic gl);
    logic        exp_ir;
    logic [4:0]  w_rd;
    logic [31:0] w_dat;
    rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    exp_ir = !r && !(busy_m[rs1] || busy_m[rs2] || busy_m[rd]);
    ga = 1'b0;
    gl = 1'b0;
    if (!r) begin
      if (av && lv) begin
        if (lsu_was_last_m) ga = 1'b1; else gl = 1'b1;
      end else begin
        ga = av;
        gl = lv;
      end
    end
    check_eq("issue_ready", 64'(issue_ready), 64'(exp_ir));
    check_eq("alu_ready",   64'(alu_ready),   64'(ga));
    check_eq("lsu_ready",   64'(lsu_ready),   64'(gl));
    check_eq("rf_we",       64'(rf_we),       64'(we_m));
    check_eq("rf_rd",       64'(rf_rd),       64'(rd_m));
    check_eq("rf_wdata",    64'(rf_wdata),    64'(wdata_m));
    check_eq("busy",        64'(busy),        64'(busy_vec()));
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      we_m = 1'b0;
      if (ga || gl) begin
        w_rd  = ga ? ard : lrd;
        w_dat = ga ? adat : ldat;
        we_m    = (w_rd != 5'd0);
        rd_m    = w_rd;
        wdata_m = w_dat;
        busy_m[w_rd]   = 1'b0;
        lsu_was_last_m = gl;
      end
      if (iv && exp_ir && rd != 5'd0) busy_m[rd] = 1'b1;
      busy_m[0] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    logic ga, gl;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
  endtask

  logic        ga, gl;
  logic        a_pend, l_pend;
  logic [4:0]  a_rd, l_rd;
  logic [31:0] a_dat, l_dat;

  initial begin
    rst = 1'b1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    @(posedge clk);
    #1;
    model_reset();

    // Contention: ALU first after reset, then LSU.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gl);
    step(0, 0, 0, 0, 0, 1, 5'd3, 32'h1111_0003, 1, 5'd4, 32'h2222_0004, ga, gl);
    check_eq("rr_first_alu", 64'(ga), 64'(1));
    step(0, 0, 0, 0, 0, 1, 5'd3, 32'h1111_0003, 1, 5'd4, 32'h2222_0004, ga, gl);
    check_eq("rr_second_lsu", 64'(gl), 64'(1));
    idle(2);

    // RAW stall until writeback of rd=5 retires.
    step(0, 1, 0, 0, 5'd5, 0, 0, 0, 0, 0, 0, ga, gl);
    step(0, 1, 5'd5, 0, 5'd6, 0, 0, 0, 0, 0, 0, ga, gl);
    step(0, 1, 5'd5, 0, 5'd6, 0, 0, 0, 0, 0, 0, ga, gl);
    step(0, 1, 5'd5, 0, 5'd6, 1, 5'd5, 32'hCAFE_0005, 0, 0, 0, ga, gl);
    step(0, 1, 5'd5, 0, 5'd6, 0, 0, 0, 0, 0, 0, ga, gl);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 5'd6, 32'h6, 0, 0, 0, ga, gl);
    idle(1);

    // Issue and writeback to the same idle register in one cycle.
    step(0, 1, 0, 0, 5'd7, 0, 0, 0, 1, 5'd7, 32'h7777_7777, ga, gl);
    check_eq("busy7_after", 64'(busy[7]), 64'(1));
    step(0, 0, 0, 0, 0, 1, 5'd7, 32'h7, 0, 0, 0, ga, gl);
    idle(1);

    // Writeback to x0: accepted, no write strobe.
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, ga, gl);
    check_eq("x0_accept", 64'(ga), 64'(1));
    idle(1);

    // Reset mid-flight clears the scoreboard.
    step(0, 1, 0, 0, 5'd9, 0, 0, 0, 0, 0, 0, ga, gl);
    step(1, 0, 0, 0, 0, 1, 5'd9, 32'h9, 1, 5'd2, 32'h2, ga, gl);
    step(0, 1, 5'd9, 0, 5'd1, 0, 0, 0, 0, 0, 0, ga, gl);
    step(0, 0, 0, 0, 0, 1, 5'd1, 32'h1, 0, 0, 0, ga, gl);

    // Back-to-back LSU writebacks.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'hA, ga, gl);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 32'hB, ga, gl);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hC, ga, gl);
    idle(2);

    // Random traffic; requesters hold rd/data until accepted.
    a_pend = 0; l_pend = 0; a_rd = 0; l_rd = 0; a_dat = 0; l_dat = 0;
    for (int c = 0; c < 600; c++) begin
      logic r;
      if (!a_pend && $urandom_range(2, 0) == 0) begin
        a_pend = 1; a_rd = 5'($urandom_range(7, 0)); a_dat = $urandom;
      end
      if (!l_pend && $urandom_range(2, 0) == 0) begin
        l_pend = 1; l_rd = 5'($urandom_range(7, 0)); l_dat = $urandom;
      end
      r = ($urandom_range(49, 0) == 0);
      step(r, 1'($urandom), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           5'($urandom_range(7, 0)), a_pend, a_rd, a_dat, l_pend, l_rd, l_dat, ga, gl);
      if (ga || r) a_pend = 0;
      if (gl || r) l_pend = 0;
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
